// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN layer sequencer: FSM state encoding,
// timeout stage codes and default sizing.
package cnn_pkg;

    localparam int          CNN_NUM_CLASSES     = 10;
    localparam int          CNN_PROB_WIDTH      = 32;
    localparam int unsigned CNN_TIMEOUT_DEFAULT = 32'd65535;
    localparam int          CNN_RESULT_WIDTH    = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONV   = 3'd1,
        ST_RELU   = 3'd2,
        ST_POOL   = 3'd3,
        ST_FC     = 3'd4,
        ST_ARGMAX = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } cnn_state_t;

    typedef enum logic [1:0] {
        STAGE_CONV = 2'd0,
        STAGE_RELU = 2'd1,
        STAGE_POOL = 2'd2,
        STAGE_FC   = 2'd3
    } cnn_stage_t;

    // Maps a layer-wait state to the code reported when that layer times out.
    function automatic cnn_stage_t stage_of(input cnn_state_t st);
        case (st)
            ST_CONV: stage_of = STAGE_CONV;
            ST_RELU: stage_of = STAGE_RELU;
            ST_POOL: stage_of = STAGE_POOL;
            ST_FC:   stage_of = STAGE_FC;
            default: stage_of = STAGE_CONV;
        endcase
    endfunction

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// Handshake bundle between the layer sequencer (master) and the datapath
// layers / result consumer (slave).
interface cnn_layer_sequencer_if #(
    parameter int NUM_CLASSES = cnn_pkg::CNN_NUM_CLASSES,
    parameter int PROB_WIDTH  = cnn_pkg::CNN_PROB_WIDTH
);
    logic                              start;
    logic                              conv_done;
    logic                              relu_done;
    logic                              pool_done;
    logic                              fc_done;
    logic [NUM_CLASSES*PROB_WIDTH-1:0] prob_bus;
    logic                              conv_enable;
    logic                              relu_enable;
    logic                              pool_enable;
    logic                              fc_enable;
    logic                              busy;
    logic [3:0]                        result;
    logic                              result_valid;
    logic                              timeout_err;
    logic [1:0]                        err_stage;

    modport master (
        input  start, conv_done, relu_done, pool_done, fc_done, prob_bus,
        output conv_enable, relu_enable, pool_enable, fc_enable,
        output busy, result, result_valid, timeout_err, err_stage
    );

    modport slave (
        output start, conv_done, relu_done, pool_done, fc_done, prob_bus,
        input  conv_enable, relu_enable, pool_enable, fc_enable,
        input  busy, result, result_valid, timeout_err, err_stage
    );
endinterface

// File: rtl/cnn_argmax_seq.sv
// Class-score register file and one-class-per-cycle signed argmax. The final
// index is held in idx until the next completed scan; done pulses with it.
module cnn_argmax_seq #(
    parameter int NUM_CLASSES = cnn_pkg::CNN_NUM_CLASSES,
    parameter int PROB_WIDTH  = cnn_pkg::CNN_PROB_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              capture,
    input  logic                              run,
    input  logic [NUM_CLASSES*PROB_WIDTH-1:0] prob_bus,
    output logic [3:0]                        idx,
    output logic                              done,
    output logic                              last
);
    localparam int KW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    logic signed [PROB_WIDTH-1:0] score_r [NUM_CLASSES];
    logic signed [PROB_WIDTH-1:0] best_r;
    logic signed [PROB_WIDTH-1:0] best_next_s;
    logic signed [PROB_WIDTH-1:0] score_k_s;
    logic [3:0]                   best_idx_r;
    logic [3:0]                   idx_next_s;
    logic [3:0]                   idx_r;
    logic [KW-1:0]                k_r;
    logic                         done_r;

    assign last = run && (k_r == KW'(NUM_CLASSES - 1));
    assign idx  = idx_r;
    assign done = done_r;

    // Compare step: class 0 seeds the scan, later classes replace only on strictly greater.
    always_comb begin
        score_k_s   = score_r[k_r];
        best_next_s = best_r;
        idx_next_s  = best_idx_r;
        if ((k_r == {KW{1'b0}}) || (score_k_s > best_r)) begin
            best_next_s = score_k_s;
            idx_next_s  = 4'(k_r);
        end else begin
            best_next_s = best_r;
            idx_next_s  = best_idx_r;
        end
    end

    // Score register file, loaded only in the fc_done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                score_r[i] <= {PROB_WIDTH{1'b0}};
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                score_r[i] <= prob_bus[i*PROB_WIDTH +: PROB_WIDTH];
            end
        end
    end

    // Scan index, running best and the held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_r        <= {KW{1'b0}};
            best_r     <= {PROB_WIDTH{1'b0}};
            best_idx_r <= 4'd0;
            idx_r      <= 4'd0;
            done_r     <= 1'b0;
        end else begin
            done_r <= last;
            if (run) begin
                k_r        <= last ? {KW{1'b0}} : k_r + {{(KW-1){1'b0}}, 1'b1};
                best_r     <= best_next_s;
                best_idx_r <= idx_next_s;
            end else begin
                k_r <= {KW{1'b0}};
            end
            if (last) begin
                idx_r <= idx_next_s;
            end
        end
    end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Layer schedule controller: pulses each layer enable in turn, waits on its done
// with a timeout guard, then runs a sequential argmax over the fc scores.
module cnn_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int          NUM_CLASSES    = CNN_NUM_CLASSES,
    parameter int          PROB_WIDTH     = CNN_PROB_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = CNN_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    cnn_layer_sequencer_if.master bus
);
    localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

    cnn_state_t  state_r;
    cnn_state_t  state_s;
    cnn_stage_t  err_stage_r;
    logic [31:0] wait_cnt_r;
    logic        in_layer_s;
    logic        tmo_hit_s;
    logic        accept_s;
    logic        timeout_s;
    logic        argmax_last_s;
    logic        argmax_done_s;
    logic [3:0]  argmax_idx_s;
    logic        conv_enable_r;
    logic        relu_enable_r;
    logic        pool_enable_r;
    logic        fc_enable_r;
    logic        busy_r;
    logic        timeout_err_r;

    assign in_layer_s = (state_r == ST_CONV) || (state_r == ST_RELU) ||
                        (state_r == ST_POOL) || (state_r == ST_FC);
    assign tmo_hit_s  = (TMO != 32'd0) && (wait_cnt_r == TMO);

    // Next-state logic; a layer's own done takes priority over its timeout.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s  = ST_CONV;
                    accept_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (bus.conv_done)  state_s = ST_RELU;
                else if (tmo_hit_s) begin state_s = ST_ERROR; timeout_s = 1'b1; end
                else                state_s = ST_CONV;
            end
            ST_RELU: begin
                if (bus.relu_done)  state_s = ST_POOL;
                else if (tmo_hit_s) begin state_s = ST_ERROR; timeout_s = 1'b1; end
                else                state_s = ST_RELU;
            end
            ST_POOL: begin
                if (bus.pool_done)  state_s = ST_FC;
                else if (tmo_hit_s) begin state_s = ST_ERROR; timeout_s = 1'b1; end
                else                state_s = ST_POOL;
            end
            ST_FC: begin
                if (bus.fc_done)    state_s = ST_ARGMAX;
                else if (tmo_hit_s) begin state_s = ST_ERROR; timeout_s = 1'b1; end
                else                state_s = ST_FC;
            end
            ST_ARGMAX: begin
                if (argmax_last_s) state_s = ST_DONE;
                else               state_s = ST_ARGMAX;
            end
            ST_DONE:  state_s = ST_IDLE;
            ST_ERROR: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State, wait counter and registered enable/busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            wait_cnt_r    <= 32'd0;
            conv_enable_r <= 1'b0;
            relu_enable_r <= 1'b0;
            pool_enable_r <= 1'b0;
            fc_enable_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            wait_cnt_r    <= (in_layer_s && (state_s == state_r)) ? wait_cnt_r + 32'd1 : 32'd0;
            conv_enable_r <= (state_s == ST_CONV) && (state_r != ST_CONV);
            relu_enable_r <= (state_s == ST_RELU) && (state_r != ST_RELU);
            pool_enable_r <= (state_s == ST_POOL) && (state_r != ST_POOL);
            fc_enable_r   <= (state_s == ST_FC)   && (state_r != ST_FC);
            busy_r        <= (state_s != ST_IDLE);
        end
    end

    // Sticky timeout flag, cleared only by the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err_r <= 1'b0;
            err_stage_r   <= STAGE_CONV;
        end else if (accept_s) begin
            timeout_err_r <= 1'b0;
            err_stage_r   <= STAGE_CONV;
        end else if (timeout_s) begin
            timeout_err_r <= 1'b1;
            err_stage_r   <= stage_of(state_r);
        end
    end

    cnn_argmax_seq #(
        .NUM_CLASSES (NUM_CLASSES),
        .PROB_WIDTH  (PROB_WIDTH)
    ) u_argmax (
        .clk      (clk),
        .rst      (rst),
        .capture  ((state_r == ST_FC) && bus.fc_done),
        .run      (state_r == ST_ARGMAX),
        .prob_bus (bus.prob_bus),
        .idx      (argmax_idx_s),
        .done     (argmax_done_s),
        .last     (argmax_last_s)
    );

    assign bus.conv_enable  = conv_enable_r;
    assign bus.relu_enable  = relu_enable_r;
    assign bus.pool_enable  = pool_enable_r;
    assign bus.fc_enable    = fc_enable_r;
    assign bus.busy         = busy_r;
    assign bus.result       = argmax_idx_s;
    assign bus.result_valid = argmax_done_s;
    assign bus.timeout_err  = timeout_err_r;
    assign bus.err_stage    = err_stage_r;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Cycle-scripted bench: plays the layers with random done latencies and random
// scores, predicting every pulse, the argmax result and timeout behaviour.
module tb_cnn_layer_sequencer;
    localparam int NC  = 10;
    localparam int PW  = 32;
    localparam int TMO = 16;

    logic clk;
    logic rst;
    int   chk_cnt;
    int   err_cnt;
    logic [3:0] last_res;
    logic signed [PW-1:0] sc_q [NC];
    int   dly_q [4];

    cnn_layer_sequencer_if #(.NUM_CLASSES(NC), .PROB_WIDTH(PW)) bus ();

    cnn_layer_sequencer #(
        .NUM_CLASSES    (NC),
        .PROB_WIDTH     (PW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] pulses();
        return {bus.result_valid, bus.conv_enable, bus.relu_enable, bus.pool_enable, bus.fc_enable};
    endfunction

    // Highest score wins; equal scores keep the earliest class.
    function automatic logic [3:0] ref_argmax();
        int best_k = 0;
        for (int k = 1; k < NC; k++) begin
            if (sc_q[k] > sc_q[best_k]) best_k = k;
        end
        return 4'(best_k);
    endfunction

    task automatic set_done(input int s, input logic v);
        case (s)
            0:       bus.conv_done = v;
            1:       bus.relu_done = v;
            2:       bus.pool_done = v;
            default: bus.fc_done   = v;
        endcase
    endtask

    task automatic run_inf(input int withhold, input bit stray, input bit rst_mid);
        logic [3:0] exp_res;
        exp_res = ref_argmax();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_val("busy_on_accept", bus.busy, 64'd1);
        check_val("err_clear_on_accept", {bus.timeout_err, bus.err_stage}, 64'd0);
        for (int s = 0; s < 4; s++) begin
            check_val($sformatf("enable_stage%0d", s), pulses(), 64'd8 >> s);
            if (withhold == s) begin
                for (int i = 1; i <= TMO; i++) begin
                    @(negedge clk);
                    check_val("wait_quiet_tmo", {pulses(), bus.timeout_err}, 64'd0);
                end
                @(negedge clk);
                check_val("timeout_flag", {bus.busy, bus.timeout_err, bus.err_stage}, {62'd3, 2'(s)});
                @(negedge clk);
                check_val("timeout_exit", {bus.busy, bus.timeout_err, bus.result_valid}, 64'd2);
                check_val("result_hold_err", bus.result, last_res);
                return;
            end
            if (rst_mid && s == 3) begin
                @(negedge clk);
                rst = 1'b1;
                #1;
                check_val("rst_mid_outputs",
                          {pulses(), bus.busy, bus.timeout_err, bus.err_stage, bus.result}, 64'd0);
                @(negedge clk);
                rst = 1'b0;
                last_res = 4'd0;
                return;
            end
            for (int i = 0; i < dly_q[s]; i++) begin
                if (stray && i == 0 && s == 0) bus.fc_done = 1'b1;
                if (stray && i == 0 && s == 1) bus.start = 1'b1;
                if (i > 0) check_val("wait_quiet", pulses(), 64'd0);
                @(negedge clk);
                bus.fc_done = 1'b0;
                bus.start   = 1'b0;
            end
            set_done(s, 1'b1);
            if (s == 3) begin
                for (int k = 0; k < NC; k++) bus.prob_bus[k*PW +: PW] = sc_q[k];
            end
            @(negedge clk);
            set_done(s, 1'b0);
            if (s == 3) bus.prob_bus = {NC{$urandom()}};
        end
        for (int i = 1; i <= NC; i++) begin
            check_val("argmax_quiet", {pulses(), bus.busy}, 64'd1);
            @(negedge clk);
        end
        check_val("result_valid", {bus.result_valid, bus.busy, bus.result}, {58'd3, exp_res});
        @(negedge clk);
        check_val("after_done", {bus.result_valid, bus.busy, bus.result}, {60'd0, exp_res});
        last_res = exp_res;
    endtask

    task automatic rand_delays(input int lo, input int hi);
        for (int s = 0; s < 4; s++) dly_q[s] = $urandom_range(hi, lo);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic signed [PW-1:0] nominal [NC];
        chk_cnt       = 0;
        err_cnt       = 0;
        last_res      = 4'd0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.conv_done = 1'b0;
        bus.relu_done = 1'b0;
        bus.pool_done = 1'b0;
        bus.fc_done   = 1'b0;
        bus.prob_bus  = '0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs",
                  {pulses(), bus.busy, bus.timeout_err, bus.err_stage, bus.result}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        nominal = '{32'sd5, -32'sd2, 32'sd9, 32'sd0, 32'sd1, 32'sd3, -32'sd7, 32'sd4, 32'sd2, 32'sd8};
        sc_q = nominal;
        for (int s = 0; s < 4; s++) dly_q[s] = 3;
        run_inf(-1, 1'b0, 1'b0);

        for (int k = 0; k < NC; k++) sc_q[k] = -32'sd1;
        sc_q[3] = 32'sh7FFF_FFFF;
        rand_delays(0, 12);
        run_inf(-1, 1'b0, 1'b0);

        for (int k = 0; k < NC; k++) sc_q[k] = 32'sh1234_5678;
        rand_delays(0, 12);
        run_inf(-1, 1'b0, 1'b0);

        rand_delays(0, 12);
        run_inf(2, 1'b0, 1'b0);
        @(negedge clk);

        for (int k = 0; k < NC; k++) sc_q[k] = $urandom_range(100, 0);
        sc_q[6] = 32'sd1000;
        dly_q = '{16, 0, 5, 2};
        run_inf(-1, 1'b0, 1'b0);

        for (int k = 0; k < NC; k++) sc_q[k] = -32'sd50 + $signed(32'($urandom_range(40, 0)));
        sc_q[9] = 32'sd77;
        dly_q = '{3, 4, 2, 6};
        run_inf(-1, 1'b1, 1'b0);

        rand_delays(1, 8);
        run_inf(-1, 1'b0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < NC; k++) begin
                if (r % 2 == 1) sc_q[k] = $signed(32'($urandom_range(6, 0))) - 32'sd3;
                else            sc_q[k] = $urandom();
            end
            rand_delays(0, 12);
            run_inf(-1, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
